// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Round-robin arbiter that owns the select of a shared WIDTH-bit 2:1 mux
//   between two burst requesters (A = pixel fetch, B = filter write-back).
//   It grants one requester at a time and counts the beats of each burst.
//   A burst is released on last_x, when req_x drops, or after MAX_BURST beats.
//   On release the mux goes straight to a waiting requester with no idle cycle.
//
// Parameters
//   WIDTH      data width of each requester and of the output
//   MAX_BURST  maximum beats per grant before forced release (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_a/b    requester wants or continues a burst
//   last_a/b   current beat is the final beat of the burst
//   data_a/b   requester data (mux input 0 / 1)
//   gnt_a/b    requester owns the mux this cycle (registered)
//   sel        mux select, 0 = A, 1 = B (registered, held while idle)
//   data_out   forwarded data of the owner
//   valid_out  data_out carries an accepted beat
//
// Configuration
//   MUX_ARB_OUTREG_EN  when defined, data_out/valid_out are registered and
//                      trail the beat by one cycle; otherwise both are
//                      combinational in the beat cycle.

module mux_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             last_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic             last_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_inc;
  logic            last_served;  // 0 = A, 1 = B
  logic            beat;
  logic            hit_max;
  logic [WIDTH-1:0] mux_data;

  // A beat is a cycle where the current owner keeps its request up.
  assign beat      = (gnt_a && req_a) || (gnt_b && req_b);
  assign count_inc = count + 1'b1;
  assign hit_max   = (count_inc == MAX_CNT);
  assign mux_data  = sel ? data_b : data_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      sel         <= 1'b0;
      count       <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // On a tie the requester that was not served last wins.
          if (req_a && (!req_b || last_served)) begin
            state <= OWN_A;
            gnt_a <= 1'b1;
            sel   <= 1'b0;
          end else if (req_b) begin
            state <= OWN_B;
            gnt_b <= 1'b1;
            sel   <= 1'b1;
          end
        end
        OWN_A: begin
          if (!req_a || last_a || hit_max) begin
            last_served <= 1'b0;
            count       <= '0;
            gnt_a       <= 1'b0;
            if (req_b) begin
              state <= OWN_B;
              gnt_b <= 1'b1;
              sel   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count_inc;
          end
        end
        OWN_B: begin
          if (!req_b || last_b || hit_max) begin
            last_served <= 1'b1;
            count       <= '0;
            gnt_b       <= 1'b0;
            if (req_a) begin
              state <= OWN_A;
              gnt_a <= 1'b1;
              sel   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count_inc;
          end
        end
        default: begin
          state <= IDLE;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

`ifdef MUX_ARB_OUTREG_EN
  // Registered output: data holds the last accepted beat between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= beat;
      if (beat) begin
        data_out <= mux_data;
      end
    end
  end
`else
  assign data_out  = mux_data;
  assign valid_out = beat;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter
//   Directed bench for mux_arbiter (WIDTH=32, MAX_BURST=8). Each cycle the
//   inputs are driven 1 ns after the rising edge and outputs are checked
//   1 ns later against hand-computed grant/select/beat/mux values. With
//   MUX_ARB_OUTREG_EN defined the data/valid expectations are delayed by one
//   cycle and data holds the last beat.

module tb_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_a;
  logic        last_a;
  logic [31:0] data_a;
  logic        req_b;
  logic        last_b;
  logic [31:0] data_b;
  logic        gnt_a;
  logic        gnt_b;
  logic        sel;
  logic [31:0] data_out;
  logic        valid_out;

  int checks;
  int failures;

  // Output model state for the registered-output build.
  logic        prev_beat;
  logic [31:0] held_data;

  mux_arbiter #(.WIDTH(32), .MAX_BURST(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .last_a    (last_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .last_b    (last_b),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check grants/select and the data path, then
  // advance to 1 ns after the next rising edge.
  task automatic cyc(input string tag,
                     input logic ra, input logic la, input logic [31:0] da,
                     input logic rb, input logic lb, input logic [31:0] db,
                     input logic e_ga, input logic e_gb, input logic e_sel,
                     input logic e_beat, input logic [31:0] e_mux);
    req_a = ra; last_a = la; data_a = da;
    req_b = rb; last_b = lb; data_b = db;
    #1;
    chk({tag, ".gnt_a"}, {31'd0, gnt_a}, {31'd0, e_ga});
    chk({tag, ".gnt_b"}, {31'd0, gnt_b}, {31'd0, e_gb});
    chk({tag, ".sel"},   {31'd0, sel},   {31'd0, e_sel});
`ifdef MUX_ARB_OUTREG_EN
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, prev_beat});
    chk({tag, ".data"},  data_out, held_data);
    if (e_beat) held_data = e_mux;
    prev_beat = e_beat;
`else
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, e_beat});
    chk({tag, ".data"},  data_out, e_mux);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    prev_beat = 1'b0; held_data = '0;
    rst_n = 1'b0;
    req_a = 0; last_a = 0; data_a = '0;
    req_b = 0; last_b = 0; data_b = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset.gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("reset.gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("reset.sel",   {31'd0, sel},   32'd0);
    chk("reset.valid", {31'd0, valid_out}, 32'd0);
    chk("reset.data",  data_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single A burst of three beats.
    cyc("a0", 1,0,32'h11, 0,0,32'h0, 0,0,0, 0,32'h11);
    cyc("a1", 1,0,32'h11, 0,0,32'h0, 1,0,0, 1,32'h11);
    cyc("a2", 1,0,32'h22, 0,0,32'h0, 1,0,0, 1,32'h22);
    cyc("a3", 1,1,32'h33, 0,0,32'h0, 1,0,0, 1,32'h33);
    cyc("a4", 0,0,32'h0,  0,0,32'h0, 0,0,0, 0,32'h0);

    // Reset in the middle of an A burst.
    cyc("r0", 1,0,32'h55, 0,0,32'h0, 0,0,0, 0,32'h55);
    cyc("r1", 1,0,32'h55, 0,0,32'h0, 1,0,0, 1,32'h55);
    req_a = 1; data_a = 32'h66;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmid.gnt_a", {31'd0, gnt_a}, 32'd0);
    chk("rmid.gnt_b", {31'd0, gnt_b}, 32'd0);
    chk("rmid.sel",   {31'd0, sel},   32'd0);
    chk("rmid.valid", {31'd0, valid_out}, 32'd0);
`ifdef MUX_ARB_OUTREG_EN
    chk("rmid.data", data_out, 32'h0);
`else
    chk("rmid.data", data_out, 32'h66);
`endif
    prev_beat = 1'b0; held_data = '0;
    req_a = 0; data_a = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("r2", 0,0,32'h0, 0,0,32'h0, 0,0,0, 0,32'h0);

    // Tie after reset: A first, direct hand-off to B.
    cyc("t0", 1,0,32'hA1, 1,0,32'hB1, 0,0,0, 0,32'hA1);
    cyc("t1", 1,1,32'hA2, 1,0,32'hB1, 1,0,0, 1,32'hA2);
    cyc("t2", 0,0,32'h0,  1,1,32'hB2, 0,1,1, 1,32'hB2);
    cyc("t3", 0,0,32'h0,  0,0,32'hB3, 0,0,1, 0,32'hB3);

    // Forced release of B after eight beats, A waiting.
    cyc("f0", 0,0,32'h0, 1,0,32'h100, 0,0,1, 0,32'h100);
    for (int i = 1; i <= 8; i++) begin
      cyc($sformatf("f%0d", i), 1,0,32'hAA, 1,0,32'h100 + i, 0,1,1, 1,32'h100 + i);
    end
    cyc("f9",  1,1,32'hAA, 1,0,32'h200, 1,0,0, 1,32'hAA);
    cyc("f10", 0,0,32'h0,  0,0,32'h300, 0,1,1, 0,32'h300);
    cyc("f11", 0,0,32'h0,  0,0,32'h301, 0,0,1, 0,32'h301);

    // A drops its request after two beats without last_a.
    cyc("d0", 1,0,32'h1, 0,0,32'hB0, 0,0,1, 0,32'hB0);
    cyc("d1", 1,0,32'h1, 0,0,32'hB0, 1,0,0, 1,32'h1);
    cyc("d2", 1,0,32'h2, 0,0,32'hB0, 1,0,0, 1,32'h2);
    cyc("d3", 0,0,32'h3, 0,0,32'hB0, 1,0,0, 0,32'h3);
    cyc("d4", 0,0,32'h4, 0,0,32'hB0, 0,0,0, 0,32'h4);

    // Single-beat DEADBEEF transfer, observed through the output stage.
    cyc("o0", 1,0,32'hDEADBEEF, 0,0,32'h0, 0,0,0, 0,32'hDEADBEEF);
    cyc("o1", 1,1,32'hDEADBEEF, 0,0,32'h0, 1,0,0, 1,32'hDEADBEEF);
    cyc("o2", 0,0,32'h0,        0,0,32'h0, 0,0,0, 0,32'h0);
    cyc("o3", 0,0,32'h7,        0,0,32'h0, 0,0,0, 0,32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
